// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline register: occupancy state and the packed
// control/datapath payloads carried between execute and memory.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic [2:0] mem_mask;
        logic [1:0] sel_wb;
    } ex_mem_ctrl_t;

    // PC+4 is carried as a 27-bit index; the upper text-space bits are implied.
    typedef struct packed {
        logic [31:0] alu_o;
        logic [31:0] wr_data;
        logic [4:0]  rd;
        logic [26:0] pc4;
        logic [4:0]  rs2_addr;
    } ex_mem_data_t;

    localparam int CTRL_BITS = $bits(ex_mem_ctrl_t);
    localparam int DATA_BITS = $bits(ex_mem_data_t);

endpackage

// File: rtl/pipe_stage_skid.sv
// EX/MEM pipeline stage with optional two-entry skid buffer; 1-cycle accept-to-valid
// latency. SKID=1 gives a registered in_ready, SKID=0 passes out_ready back to in_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_BITS,
    parameter int DATA_W = DATA_BITS,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        occ_q, occ_d;

    logic main_vld;
    logic skid_vld;
    logic accept;
    logic pop;

    assign main_vld = (state_q != EMPTY);
    assign skid_vld = (state_q == TWO);

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !skid_vld && !flush && !rst;
        end else begin : g_single
            assign in_ready = (!main_vld || out_ready) && !flush && !rst;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        occ_d       = occ_q;
        accept      = in_valid && in_ready;
        pop         = main_vld && out_ready;

        // Flush masks the head so downstream write enables cannot fire this cycle.
        out_valid = main_vld && !flush;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        out_data  = flush ? '0 : main_data_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                        main_data_d = '0;
                    end
                end
                TWO: begin
                    // Older entry lives in main, so draining always promotes skid.
                    if (pop) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        case (state_d)
            ONE:     occ_d = 2'd1;
            TWO:     occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            occ_q       <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic, scored
// against a capacity-limited FIFO model of the stage.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = CTRL_BITS;
    localparam int DW = DATA_BITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    logic          b_flush;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [CW-1:0] b_in_ctrl;
    logic [DW-1:0] b_in_data;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occupancy;

    int compared   = 0;
    int mismatched = 0;
    bit mon_en     = 1'b0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;
    beat_t model_q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut_single (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [127:0] val);
        in_valid = v;
        in_ctrl  = val[CW-1:0];
        in_data  = val[DW-1:0];
    endtask

    // Scoreboard: compares against the model queue, then advances it to the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_vld;
            logic exp_rdy;
            exp_vld = (model_q.size() > 0) && !flush;
            exp_rdy = !rst && !flush && (model_q.size() < 2);
            chk("mon_out_valid", out_valid, exp_vld);
            chk("mon_in_ready", in_ready, exp_rdy);
            chk("mon_occupancy", occupancy, model_q.size());
            if (exp_vld) begin
                chk("mon_out_data", out_data, model_q[0].d);
                chk("mon_out_ctrl", out_ctrl, model_q[0].c);
            end else begin
                chk("mon_ctrl_zero", out_ctrl, 0);
            end
            if (flush) chk("mon_flush_data", out_data, 0);

            if (rst || flush) begin
                model_q.delete();
            end else begin
                if (exp_vld && out_ready) void'(model_q.pop_front());
                if (in_valid && exp_rdy) model_q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 0);
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset
        step();
        mon_en = 1'b1;
        step();
        at_neg();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        step();
        rst = 1'b0;
        at_neg();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_b_in_ready", b_in_ready, 1);

        // Two beats into a stalled stage, then drain in order
        step(); offer(1'b1, 'hA5);
        step(); offer(1'b1, 'h3C);
        step(); offer(1'b0, 0);
        at_neg();
        chk("skid_occ2", occupancy, 2);
        chk("skid_in_ready0", in_ready, 0);
        chk("skid_head_A5", out_data, 'hA5);
        step();
        at_neg();
        chk("skid_hold_A5", out_data, 'hA5);
        step(); out_ready = 1'b1;
        at_neg();
        chk("drain_first_A5", out_data, 'hA5);
        step();
        at_neg();
        chk("drain_second_3C", out_data, 'h3C);
        step();
        at_neg();
        chk("drain_empty", out_valid, 0);

        // Full-rate streaming
        for (int i = 0; i < 10; i++) begin
            step(); offer(1'b1, i);
            at_neg();
            if (i > 0) begin
                chk("stream_data", out_data, i - 1);
                chk("stream_occ", occupancy, 1);
            end
        end
        step(); offer(1'b0, 0);
        at_neg();
        chk("stream_last", out_data, 9);
        step();

        // Flush while full with a beat on offer
        out_ready = 1'b0;
        step(); offer(1'b1, 'h11);
        step(); offer(1'b1, 'h22);
        step(); offer(1'b1, 'h77); flush = 1'b1;
        at_neg();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_in_ready", in_ready, 0);
        step(); offer(1'b0, 0); flush = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("flush_occ0", occupancy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg();
            chk("flush_no_77", out_valid, 0);
        end

        // Reset mid-operation at occupancy 2
        out_ready = 1'b0;
        step(); offer(1'b1, 'h44);
        step(); offer(1'b1, 'h55);
        step(); offer(1'b1, 'h66); rst = 1'b1;
        at_neg();
        chk("midrst_occ2", occupancy, 2);
        step(); offer(1'b0, 0); rst = 1'b0;
        at_neg();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_ctrl", out_ctrl, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);

        // Single-register variant: ready follows out_ready combinationally
        step(); b_in_valid = 1'b1; b_in_ctrl = 'h55; b_in_data = 'h55;
        step(); b_in_ctrl = 'h66; b_in_data = 'h66;
        at_neg();
        chk("single_in_ready0", b_in_ready, 0);
        chk("single_occ1", b_occupancy, 1);
        chk("single_head_55", b_out_data, 'h55);
        step(); b_out_ready = 1'b1;
        at_neg();
        chk("single_in_ready1", b_in_ready, 1);
        chk("single_still_55", b_out_data, 'h55);
        step(); b_in_valid = 1'b0; b_out_ready = 1'b0;
        at_neg();
        chk("single_replaced_66", b_out_data, 'h66);
        chk("single_occ_after", b_occupancy, 1);

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            logic [127:0] r;
            step();
            r         = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 9) < 6);
            in_ctrl   = r[127:128-CW];
            in_data   = r[DW-1:0];
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            b_in_valid  = ($urandom_range(0, 1) == 1);
            b_out_ready = ($urandom_range(0, 1) == 1);
            b_in_data   = r[DW-1:0];
            b_in_ctrl   = r[CW-1:0];
            at_neg();
            chk("single_occ_max1", (b_occupancy <= 2'd1), 1);
            if (!b_out_valid) chk("single_ctrl_zero", b_out_ctrl, 0);
        end

        step();
        offer(1'b0, 0); flush = 1'b0; out_ready = 1'b0;
        at_neg();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
